// File: rtl/ddr2_port_arbiter.sv
// Purpose: round-robin share of one DDR2 controller user port among NPORTS requesters.
// Latency: p_req (with c_rdy) at edge k -> c_*_req from edge k+1; c_ack at edge m -> p_ack from edge m+1.
// Backpressure: no grant while c_rdy is low; the request level is held until c_ack or watchdog abort.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   p_req/p_we/p_addr/p_wdata  per-port request level, op (1 = write), address, write data
//   p_ack/p_err/p_rdata    per-port completion pulse, abort pulse, shared read data
//   c_addr/c_data_in/c_rd_req/c_wr_req  latched command to the controller
//   c_data_out/c_rdy/c_ack controller read data, idle flag, completion pulse
//   busy, cur_port         transaction in flight, granted / last-granted port
module ddr2_port_arbiter #(
    parameter int NPORTS  = 4,
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NPORTS-1:0]        p_req,
    input  logic [NPORTS-1:0]        p_we,
    input  logic [NPORTS*ADDR_W-1:0] p_addr,
    input  logic [NPORTS*DATA_W-1:0] p_wdata,
    output logic [NPORTS-1:0]        p_ack,
    output logic [NPORTS-1:0]        p_err,
    output logic [DATA_W-1:0]        p_rdata,
    output logic [ADDR_W-1:0]        c_addr,
    output logic [DATA_W-1:0]        c_data_in,
    output logic                     c_rd_req,
    output logic                     c_wr_req,
    input  logic [DATA_W-1:0]        c_data_out,
    input  logic                     c_rdy,
    input  logic                     c_ack,
    output logic                     busy,
    output logic [2:0]               cur_port
);

    localparam logic ST_ARB   = 1'b0;
    localparam logic ST_ISSUE = 1'b1;
    localparam int   WD_W     = $clog2(TIMEOUT);

    logic              state;
    logic [2:0]        rr_ptr;
    logic [WD_W-1:0]   wdog;
    logic              grant_found;
    logic [2:0]        grant_idx;
    int                cand;
    logic [NPORTS-1:0] cur_onehot;

    // Cyclic search starting just after the last winner; the last winner
    // itself is visited last, which is what makes the rotation fair.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 3'd0;
        cand        = 0;
        for (int k = 1; k <= NPORTS; k++) begin
            cand = (int'(rr_ptr) + k) % NPORTS;
            if (!grant_found && p_req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = 3'(cand);
            end
        end
    end

    assign cur_onehot = {{(NPORTS-1){1'b0}}, 1'b1} << cur_port;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ARB;
            rr_ptr    <= 3'(NPORTS-1);
            wdog      <= '0;
            p_ack     <= '0;
            p_err     <= '0;
            p_rdata   <= '0;
            c_addr    <= '0;
            c_data_in <= '0;
            c_rd_req  <= 1'b0;
            c_wr_req  <= 1'b0;
            busy      <= 1'b0;
            cur_port  <= 3'd0;
        end else begin
            p_ack <= '0;
            p_err <= '0;
            case (state)
                ST_ARB: begin
                    if (c_rdy && grant_found) begin
                        c_addr    <= p_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                        c_data_in <= p_wdata[int'(grant_idx)*DATA_W +: DATA_W];
                        c_wr_req  <= p_we[grant_idx];
                        c_rd_req  <= ~p_we[grant_idx];
                        cur_port  <= grant_idx;
                        rr_ptr    <= grant_idx;
                        wdog      <= '0;
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // The controller re-samples the request level, so the
                    // command stays put until ack or abort.
                    if (c_ack) begin
                        if (c_rd_req) begin
                            p_rdata <= c_data_out;
                        end
                        c_rd_req <= 1'b0;
                        c_wr_req <= 1'b0;
                        p_ack    <= cur_onehot;
                        busy     <= 1'b0;
                        state    <= ST_ARB;
                    end else if (wdog == WD_W'(TIMEOUT-1)) begin
                        c_rd_req <= 1'b0;
                        c_wr_req <= 1'b0;
                        p_ack    <= cur_onehot;
                        p_err    <= cur_onehot;
                        busy     <= 1'b0;
                        state    <= ST_ARB;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr2_port_arbiter.sv
module tb_ddr2_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 26;
    localparam int DW = 64;

    logic            clk;
    logic            rst_n;
    logic [NP-1:0]   p_req;
    logic [NP-1:0]   p_we;
    logic [NP*AW-1:0] p_addr;
    logic [NP*DW-1:0] p_wdata;
    logic [NP-1:0]   p_ack;
    logic [NP-1:0]   p_err;
    logic [DW-1:0]   p_rdata;
    logic [AW-1:0]   c_addr;
    logic [DW-1:0]   c_data_in;
    logic            c_rd_req;
    logic            c_wr_req;
    logic [DW-1:0]   c_data_out;
    logic            c_rdy;
    logic            c_ack;
    logic            busy;
    logic [2:0]      cur_port;

    int vectors = 0;
    int miscompares = 0;

    ddr2_port_arbiter #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_ack(p_ack), .p_err(p_err), .p_rdata(p_rdata),
        .c_addr(c_addr), .c_data_in(c_data_in), .c_rd_req(c_rd_req), .c_wr_req(c_wr_req),
        .c_data_out(c_data_out), .c_rdy(c_rdy), .c_ack(c_ack),
        .busy(busy), .cur_port(cur_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Controller model: waits (bounded) for a grant, holds for dly cycles
    // observing the command, then acks with c_rdy low (precharge tail).
    task automatic serve(input int dly, output int port, output int hi,
                         output int unstable, output int rd_seen);
        int t;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic r0, w0;
        t = 0;
        while (!busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("grant_wait", busy, 1);
        port = int'(cur_port);
        a0 = c_addr; d0 = c_data_in; r0 = c_rd_req; w0 = c_wr_req;
        hi = 0; unstable = 0; rd_seen = 0;
        for (int i = 0; i < dly; i++) begin
            if (i > 0) @(negedge clk);
            if (c_rd_req | c_wr_req) hi++;
            if (c_addr !== a0 || c_data_in !== d0 || c_rd_req !== r0 || c_wr_req !== w0) unstable++;
            if (c_rd_req) rd_seen++;
            if (i == dly-1) begin
                c_ack = 1'b1;
                c_rdy = 1'b0;
            end
        end
        @(negedge clk);
        c_ack = 1'b0;
        if (c_rd_req | c_wr_req) hi++;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int port, hi, unst, rds, t;
        logic [63:0] rdexp;
        rst_n = 1'b0; p_req = '0; p_we = '0; p_addr = '0; p_wdata = '0;
        c_data_out = '0; c_rdy = 1'b1; c_ack = 1'b0;
        for (int i = 0; i < NP; i++) begin
            p_addr[i*AW +: AW]  = AW'(32'h100 * (i + 1));
            p_wdata[i*DW +: DW] = 64'h1111_0000_0000_0000 * (i + 1);
        end

        // Reset state
        #12;
        chk("rst_c_rd_req", c_rd_req, 0);
        chk("rst_c_wr_req", c_wr_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur_port", cur_port, 0);
        chk("rst_p_ack", p_ack, 0);
        chk("rst_p_rdata", p_rdata, 0);
        chk("rst_c_addr", c_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Single read, port 2, ack after 10 cycles
        p_addr[2*AW +: AW] = 26'h1ABCDEF;
        p_we[2] = 1'b0;
        p_req[2] = 1'b1;
        c_data_out = 64'hDEADBEEF_01234567;
        serve(10, port, hi, unst, rds);
        chk("rd_port", port, 2);
        chk("rd_hi_cycles", hi, 10);
        chk("rd_stable", unst, 0);
        chk("rd_addr", c_addr, 26'h1ABCDEF);
        chk("rd_p_ack", p_ack, 4'b0100);
        chk("rd_p_err", p_err, 0);
        chk("rd_p_rdata", p_rdata, 64'hDEADBEEF_01234567);
        chk("rd_busy_done", busy, 0);
        rdexp = 64'hDEADBEEF_01234567;
        p_req[2] = 1'b0;
        @(negedge clk);
        chk("rd_ack_width", p_ack, 0);
        c_rdy = 1'b1;
        c_data_out = 64'hFFFF_FFFF_FFFF_FFFF;

        // Single write, port 0, ack after 2 cycles
        p_wdata[0*DW +: DW] = 64'h55AA55AA_55AA55AA;
        p_we[0] = 1'b1;
        p_req[0] = 1'b1;
        serve(2, port, hi, unst, rds);
        chk("wr_port", port, 0);
        chk("wr_hi_cycles", hi, 2);
        chk("wr_stable", unst, 0);
        chk("wr_no_rd", rds, 0);
        chk("wr_data_in", c_data_in, 64'h55AA55AA_55AA55AA);
        chk("wr_p_ack", p_ack, 4'b0001);
        chk("wr_p_rdata_kept", p_rdata, rdexp);
        p_req[0] = 1'b0;
        @(negedge clk);
        chk("wr_ack_width", p_ack, 0);
        c_rdy = 1'b1;

        // Watchdog abort on port 1 (read), port 3 (write) pending
        p_we[1] = 1'b0; p_we[3] = 1'b1;
        p_req = 4'b1010;
        t = 0;
        while (!busy && t < 20) begin @(negedge clk); t++; end
        chk("wd_grant_port", cur_port, 1);
        hi = 0; t = 0;
        while (busy && t < 200) begin
            if (c_rd_req) hi++;
            @(negedge clk);
            t++;
        end
        chk("wd_hi_cycles", hi, 64);
        chk("wd_p_ack", p_ack, 4'b0010);
        chk("wd_p_err", p_err, 4'b0010);
        chk("wd_p_rdata_kept", p_rdata, rdexp);
        chk("wd_req_dropped", c_rd_req, 0);
        p_req[1] = 1'b0;
        @(negedge clk);
        chk("wd_next_port", cur_port, 3);
        chk("wd_next_busy", busy, 1);
        chk("wd_ack_width", p_ack, 0);

        // Race: c_ack in the timeout cycle; ack wins
        serve(64, port, hi, unst, rds);
        chk("race_port", port, 3);
        chk("race_hi_cycles", hi, 64);
        chk("race_p_ack", p_ack, 4'b1000);
        chk("race_p_err", p_err, 0);
        p_req[3] = 1'b0;
        @(negedge clk);
        c_rdy = 1'b1;

        // Async reset mid-ISSUE
        p_we[2] = 1'b0;
        p_req[2] = 1'b1;
        t = 0;
        while (!busy && t < 20) begin @(negedge clk); t++; end
        @(negedge clk);
        chk("ar_pre_rd_req", c_rd_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_c_rd_req", c_rd_req, 0);
        chk("ar_c_wr_req", c_wr_req, 0);
        chk("ar_busy", busy, 0);
        p_req = 4'b1001;
        p_we = 4'b1111;
        @(negedge clk);
        chk("ar_no_ack", p_ack, 0);
        chk("ar_no_err", p_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_winner", cur_port, 0);
        chk("ar_winner_busy", busy, 1);

        // Round robin with all ports requesting continuously
        p_req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            serve(3, port, hi, unst, rds);
            chk("rr_port", port, i % 4);
            chk("rr_p_ack", p_ack, 64'(4'b0001 << (i % 4)));
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                chk("rr_no_grant_rdy0", busy, 0);
            end
            if (i == 7) p_req = '0;
            c_rdy = 1'b1;
        end
        @(negedge clk);
        @(negedge clk);
        chk("end_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddr2_port_arbiter.md
Name: ddr2_port_arbiter

Overview:
- Round-robin arbiter that shares the single DDR2 controller user port among NPORTS requesters. The user port carries c_addr, c_data_in, c_rd_req, c_wr_req, c_data_out, c_rdy and c_ack.
- Grants one requester at a time and latches its command. It holds c_rd_req or c_wr_req stable until the controller returns c_ack, then returns a one-cycle ack (plus read data) to the winning port.
- A watchdog releases a transaction that never receives c_ack.

Parameters:
- NPORTS, 4, number of requesters (2..8).
- ADDR_W, 26, address width, matching c_addr.
- DATA_W, 64, data width, matching c_data_in and c_data_out.
- TIMEOUT, 1024, number of ISSUE cycles allowed without c_ack before abort; must be ≥ 64.

Ports:
- clk  in  1  system clock; all logic is on posedge.
- rst_n  in  1  asynchronous active-low reset.
- p_req  in  NPORTS  per-port request level; held high until that port's p_ack.
- p_we  in  NPORTS  per-port op: 1 = write, 0 = read; valid while p_req is high.
- p_addr  in  NPORTS*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W].
- p_wdata  in  NPORTS*DATA_W  per-port write data; packed the same way.
- p_ack  out  NPORTS  one-cycle completion pulse to the granted port.
- p_err  out  NPORTS  one-cycle pulse, coincident with p_ack, on watchdog abort.
- p_rdata  out  DATA_W  read data, shared by all ports; valid in the p_ack cycle of a read.
- c_addr  out  ADDR_W  to the controller; latched address.
- c_data_in  out  DATA_W  to the controller; latched write data.
- c_rd_req  out  1  read request to the controller.
- c_wr_req  out  1  write request to the controller.
- c_data_out  in  DATA_W  read data from the controller.
- c_rdy  in  1  controller idle.
- c_ack  in  1  controller one-cycle completion.
- busy  out  1  high while in ISSUE.
- cur_port  out  3  index of the granted or last-granted port.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Every output is 0: p_ack, p_err, p_rdata, c_addr, c_data_in, c_rd_req, c_wr_req, busy, cur_port.
  - state = ARB; rr_ptr = NPORTS-1, so port 0 has first priority; watchdog = 0.
  - Reset asserted mid-transaction drops c_*_req immediately; no ack or err is issued for the aborted command.
- All outputs are registered. p_ack and p_err default to 0 every cycle.
- ARB state:
  - Grants only when c_rdy = 1 and |p_req.
  - Winner is the first requesting port searched cyclically from rr_ptr+1, wrapping modulo NPORTS.
  - At the grant edge: latch p_addr[w] into c_addr and p_wdata[w] into c_data_in; set c_wr_req = p_we[w] and c_rd_req = ~p_we[w]; set cur_port = w and rr_ptr = w; clear the watchdog; go to ISSUE.
  - Exactly one of c_rd_req/c_wr_req is ever high.
  - If c_rdy = 0, wait with all requests pending.
- ISSUE state:
  - busy = 1; c_addr, c_data_in and the request bit are held constant. The controller re-samples the request level after activation, so the level must not drop early.
  - Watchdog increments each cycle.
  - On c_ack = 1:
    - clear c_*_req;
    - pulse p_ack[cur_port];
    - for a read, capture c_data_out into p_rdata in the same edge, so p_rdata is valid with p_ack;
    - for a write, p_rdata is unchanged;
    - return to ARB.
  - On watchdog = TIMEOUT-1 with no c_ack: clear c_*_req, pulse p_ack[cur_port] and p_err[cur_port], p_rdata unchanged, return to ARB.
  - c_ack and timeout in the same cycle: the ack wins and p_err stays 0.
- Back-to-back operation: after a completion, ARB may only re-grant once c_rdy is 1 again. The controller's precharge tail holds c_rdy low, so no explicit spacing counter is needed.
- Request drop: a port that drops p_req before it is granted is simply skipped. A drop after grant does not cancel the command; the p_ack is still issued.
- A c_ack outside ISSUE is ignored.
- Fairness: with all ports requesting continuously, grants rotate 0,1,2,3,0,…; no port waits more than NPORTS-1 grants.
- Latency: p_req with c_rdy = 1 at edge k gives c_*_req high from edge k+1. A c_ack sampled at edge m gives p_ack high from edge m+1 for one cycle.

Test Plan:
- Single read: port 2 requests addr 0x1ABCDEF with c_rdy = 1; the controller model acks 10 cycles later with data 0xDEADBEEF_01234567.
  - c_rd_req high for exactly 10 cycles and c_addr = 0x1ABCDEF.
  - p_ack[2] one cycle with p_rdata = 0xDEADBEEF_01234567; p_err = 0.
- Single write: port 0 writes 0x55AA…55AA and the model acks after 2 cycles.
  - c_wr_req held, c_data_in stable throughout, c_rd_req never high.
  - p_ack[0] pulses once; p_rdata unchanged.
- Round-robin: all 4 ports request continuously for 8 transactions.
  - Grant order is 0,1,2,3,0,1,2,3.
  - No grant occurs while c_rdy = 0 between transactions.
- Watchdog with TIMEOUT = 64: the model never acks.
  - Request drops after 64 ISSUE cycles; p_ack[1] and p_err[1] pulse together; the next pending port is then granted.
- Watchdog race: c_ack arrives on cycle 63 of ISSUE (the timeout cycle).
  - p_ack pulses with p_err = 0.
- Async reset: pull rst_n low mid-ISSUE between clock edges.
  - c_rd_req, c_wr_req and busy go to 0 without waiting for a clock edge.
  - After release, port 0 wins when ports 0 and 3 request simultaneously.
